dw_up_packer: RTL
=================

DW_UP_PACKER -- requirements
Module: dw_up_packer

Interface
REQ-001 SHALL provide parameter INPUT_DW, default 64: input word width in bits.
REQ-002 SHALL provide parameter OUTPUT_DW, default 512: output beat width in bits.
REQ-003 SHALL derive parameter UP_RATIO = OUTPUT_DW/INPUT_DW, which is not overridable.
REQ-004 SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port data_i, input, INPUT_DW bits: input word.
REQ-007 SHALL have port valid_i, input, 1 bit: input word valid.
REQ-008 SHALL have port last_i, input, 1 bit: input word closes the packet.
REQ-009 SHALL have port ready_o, output, 1 bit: input word accepted.
REQ-010 SHALL have port data_o, output, OUTPUT_DW bits: packed output beat.
REQ-011 SHALL have port keep_o, output, UP_RATIO bits: word-valid mask; bit k covers data_o[k*INPUT_DW +: INPUT_DW].
REQ-012 SHALL have port last_o, output, 1 bit: beat closes the packet.
REQ-013 SHALL have port valid_o, output, 1 bit: output beat valid.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts the beat.
REQ-015 SHALL have port busy_o, output, 1 bit: accumulator holds at least one word.

Function
REQ-016 SHALL accept an input word when valid_i && ready_o.
REQ-017 SHALL produce an output transfer when valid_o && ready_i.
REQ-018 SHALL write the accepted word at index idx into accumulator slot idx (little-endian; word 0 in the LSBs), then increment idx.
REQ-019 SHALL define a closing word as an accepted word with idx == UP_RATIO-1, or an accepted word with last_i=1 (macro only).
REQ-020 SHALL, on a closing word, load the output register with the accumulator merged with that word, set valid_o=1 on the next cycle, set keep_o bits 0..idx, set last_o=last_i, and clear idx and the accumulator to 0.
REQ-021 SHALL drive unfilled output words to 0.
REQ-022 SHALL drive ready_o = 1 for non-closing words regardless of output state.
REQ-023 SHALL drive ready_o = !valid_o || ready_i for closing words, so there is no combinational path from valid_i to valid_o.
REQ-024 SHALL hold data_o, keep_o, last_o and valid_o stable while valid_o && !ready_i.
REQ-025 SHALL sustain full throughput: one beat every UP_RATIO input cycles with ready_i held at 1, with no bubbles.
REQ-026 SHALL have a latency of exactly 1 cycle from the closing-word acceptance edge to valid_o.
REQ-027 SHALL, on a simultaneous output transfer and closing-word acceptance, replace the output register with the new beat in the same edge, keeping valid_o=1.
REQ-028 SHALL, when UP_RATIO==1, make every word closing, so the block acts as a one-deep registered slice.
REQ-029 SHALL drive busy_o = (idx != 0).
REQ-030 SHALL treat valid_i=0 as a hold: idx and the accumulator are unchanged, and last_i is ignored.

Reset
REQ-031 SHALL, while rst_ni=0, drive valid_o=0, data_o=0, keep_o=0, last_o=0, idx=0, accumulator=0 and busy_o=0.
REQ-032 SHALL, on reset mid-packet, discard any partial accumulator and in-flight beat without emitting them.
REQ-033 SHALL hold ready_o=1 one cycle after reset deassertion.

Configuration
REQ-034 SHALL use macro DW_UP_PACKER_LAST_EN.
REQ-035 SHALL, when DW_UP_PACKER_LAST_EN is defined, support early flush via last_i per REQ-019/020, with keep_o reflecting the partial fill.
REQ-036 SHALL, when DW_UP_PACKER_LAST_EN is undefined, keep the last_i port but ignore it, tie last_o to 0, tie keep_o to all ones, and close only at idx == UP_RATIO-1.
REQ-037 SHALL raise a fatal elaboration error if OUTPUT_DW % INPUT_DW != 0 or OUTPUT_DW < INPUT_DW.

Verification (INPUT_DW=64, OUTPUT_DW=256, UP_RATIO=4)
REQ-038 SHALL verify basic packing: words 0x11,0x22,0x33,0x44 back-to-back with ready_i=1 -> one cycle after the 4th word, valid_o=1, data_o = {0x44,0x33,0x22,0x11}, keep_o=4'hF, last_o=0.
REQ-039 SHALL verify early flush (macro on): 0xA1, then 0xA2 with last_i=1 -> data_o = {0,0,0xA2,0xA1}, keep_o=4'h3, last_o=1; busy_o=0 afterwards.
REQ-040 SHALL verify backpressure: ready_i=0 with a pending beat -> 3 further words are accepted, the 4th is stalled (ready_o=0); after ready_i=1 both beats emerge in order, unchanged.
REQ-041 SHALL verify streaming: 16 words with ready_i=1 -> 4 beats at cycles 4, 8, 12 and 16 after the first acceptance, valid_o never drops between transfers.
REQ-042 SHALL verify reset mid-packet: 2 words accepted, then rst_ni pulsed -> no beat emitted; the next 4 words form a clean beat with keep_o=4'hF.
REQ-043 SHALL verify macro off: 0xB1 with last_i=1 followed by 3 more words -> a single beat with keep_o=4'hF and last_o=0.

Source files
------------

// File: rtl/dw_up_packer.sv
// Packs INPUT_DW-bit words into OUTPUT_DW-bit beats, little-endian, with a registered output slice.
// Define DW_UP_PACKER_LAST_EN to enable early packet flush via last_i with a partial keep_o mask.
module dw_up_packer #(
   parameter int unsigned INPUT_DW  = 64,
   parameter int unsigned OUTPUT_DW = 512,
   localparam int unsigned UP_RATIO = OUTPUT_DW / INPUT_DW
) (
   input  logic                 clk,
   input  logic                 rst_ni,
   input  logic [INPUT_DW-1:0]  data_i,
   input  logic                 valid_i,
   input  logic                 last_i,
   output logic                 ready_o,
   output logic [OUTPUT_DW-1:0] data_o,
   output logic [UP_RATIO-1:0]  keep_o,
   output logic                 last_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o
);

   localparam int unsigned IDX_W = (UP_RATIO > 1) ? $clog2(UP_RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UP_RATIO - 1);

   if ((OUTPUT_DW < INPUT_DW) || ((OUTPUT_DW % INPUT_DW) != 0)) begin : g_bad_cfg
      $fatal(1, "dw_up_packer: OUTPUT_DW must be a non-zero multiple of INPUT_DW");
   end

   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [OUTPUT_DW-1:0] acc_q, acc_d;
   logic [OUTPUT_DW-1:0] data_q, data_d;
   logic [UP_RATIO-1:0]  keep_q, keep_d;
   logic                 last_q, last_d;
   logic                 valid_q, valid_d;

   logic                 flush_c;
   logic                 closing_c;
   logic                 accept_c;
   logic                 xfer_c;
   logic [OUTPUT_DW-1:0] merged_c;
   logic [UP_RATIO-1:0]  fill_mask_c;

`ifdef DW_UP_PACKER_LAST_EN
   assign flush_c = last_i;
`else
   logic unused_last_c;
   assign unused_last_c = last_i;
   assign flush_c       = 1'b0;
`endif

   // Only a closing word needs room in the output register; others always go into the accumulator.
   assign closing_c = (idx_q == LAST_IDX) || flush_c;
   assign ready_o   = closing_c ? (!valid_q || ready_i) : 1'b1;
   assign accept_c  = valid_i && ready_o;
   assign xfer_c    = valid_q && ready_i;

   // The target slot is always zero, so OR-ing the shifted word in is a slot write.
   assign merged_c = acc_q | (OUTPUT_DW'(data_i) << (32'(idx_q) * INPUT_DW));

   always_comb begin
      fill_mask_c = '0;
      for (int unsigned k = 0; k < UP_RATIO; k++) begin
         fill_mask_c[k] = (k <= 32'(idx_q));
      end
   end

   always_comb begin
      idx_d   = idx_q;
      acc_d   = acc_q;
      data_d  = data_q;
      keep_d  = keep_q;
      last_d  = last_q;
      valid_d = valid_q;

      if (xfer_c) begin
         valid_d = 1'b0;
      end

      if (accept_c) begin
         if (closing_c) begin
            idx_d   = '0;
            acc_d   = '0;
            data_d  = merged_c;
            valid_d = 1'b1;
`ifdef DW_UP_PACKER_LAST_EN
            keep_d  = fill_mask_c;
            last_d  = last_i;
`else
            keep_d  = '1;
            last_d  = 1'b0;
`endif
         end else begin
            idx_d = idx_q + IDX_W'(1);
            acc_d = merged_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q   <= '0;
         acc_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign keep_o  = keep_q;
   assign valid_o = valid_q;
   assign busy_o  = (idx_q != '0);
`ifdef DW_UP_PACKER_LAST_EN
   assign last_o  = last_q;
`else
   logic unused_fill_c;
   assign unused_fill_c = (|fill_mask_c) | last_q;
   assign last_o  = 1'b0;
`endif

endmodule
